// File: rtl/image_receive_fsm_pkg.sv
// Shared definitions for the image receive path: FSM state encodings and
// the default sync byte that precedes every echo record sent to the host.
package image_receive_fsm_pkg;

    localparam int unsigned DATA_W = 8;

    // Sync byte sent ahead of each record
    localparam logic [DATA_W-1:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLDOFF   = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SEND_HDR  = 3'd3,
        ST_HDR_WAIT  = 3'd4,
        ST_SEND      = 3'd5,
        ST_BYTE_WAIT = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

endpackage

// File: rtl/image_receive_fsm_if.sv
// Sample stream and UART transmit handshake of the image receive FSM.
//   adc_data/adc_valid : echo samples from the AFE/ADC
//   tx_busy            : UART transmitter busy
//   tx_data/new_tx_data: byte and one-cycle load strobe to the UART
// master = receive FSM side, slave = AFE/UART side.
interface image_receive_fsm_if
    import image_receive_fsm_pkg::*;
;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              tx_busy;
    logic [DATA_W-1:0] tx_data;
    logic              new_tx_data;

    modport master (
        input  adc_data,
        input  adc_valid,
        input  tx_busy,
        output tx_data,
        output new_tx_data
    );

    modport slave (
        output adc_data,
        output adc_valid,
        output tx_busy,
        input  tx_data,
        input  new_tx_data
    );

endinterface

// File: rtl/image_receive_fsm_echo_ram.sv
// Echo record buffer: simple dual-port RAM, one write port and one
// registered read port (1-cycle read latency), written to infer block RAM.
//   clk      : clock
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : registered read data
module image_receive_fsm_echo_ram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on storage or read register so the tools map this to BRAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/image_receive_fsm.sv
// Receive-side image FSM: waits for the transmit burst to end, blanks
// ringdown for HOLDOFF cycles, captures DEPTH echo samples into the echo RAM,
// then streams a header byte plus the record to the UART transmitter.
//   clk                  : system clock
//   rst                  : synchronous active-high reset
//   transmit_in_progress : falling edge arms a capture
//   bus                  : ADC sample stream and UART tx handshake (master)
//   capture_in_progress  : high in HOLDOFF and CAPTURE
//   busy                 : high in every state except IDLE
//   record_done          : one-cycle pulse after the last byte is handed off
module image_receive_fsm
    import image_receive_fsm_pkg::*;
#(
    parameter int unsigned       DEPTH   = 1024,
    parameter int unsigned       ADDR_W  = 10,
    parameter int unsigned       HOLDOFF = 16,
    parameter logic [DATA_W-1:0] HEADER  = HEADER_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                transmit_in_progress,
    image_receive_fsm_if.master bus,
    output logic                capture_in_progress,
    output logic                busy,
    output logic                record_done
);

    localparam int unsigned       HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state, state_nxt;
    logic                tip_q;
    logic                arm;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [ADDR_W-1:0]   wr_addr, wr_addr_nxt;
    logic [ADDR_W-1:0]   rd_addr, rd_addr_nxt;
    logic                prefetched;
    logic                ram_we;
    logic [DATA_W-1:0]   rd_data;
    logic                strobe_nxt;
    logic [DATA_W-1:0]   tx_data_nxt;

    // Arm on the first cycle the transmit flag is seen low after being high
    assign arm = tip_q & ~transmit_in_progress;

    image_receive_fsm_echo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_echo_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_addr),
        .wr_data (bus.adc_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state, counter and output decode
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        wr_addr_nxt  = wr_addr;
        rd_addr_nxt  = rd_addr;
        ram_we       = 1'b0;
        strobe_nxt   = 1'b0;
        tx_data_nxt  = bus.tx_data;

        case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_nxt    = ST_HOLDOFF;
                    hold_cnt_nxt = '0;
                end
            end
            ST_HOLDOFF: begin
                hold_cnt_nxt = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.adc_valid) begin
                    ram_we      = 1'b1;
                    wr_addr_nxt = wr_addr + 1'b1;
                    if (wr_addr == LAST_ADDR) begin
                        state_nxt = ST_SEND_HDR;
                    end
                end
            end
            ST_SEND_HDR: begin
                if (!bus.tx_busy) begin
                    strobe_nxt  = 1'b1;
                    tx_data_nxt = HEADER;
                    state_nxt   = ST_HDR_WAIT;
                end
            end
            ST_HDR_WAIT: begin
                // Guard cycle: UART raises busy one cycle after the strobe
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (prefetched && !bus.tx_busy) begin
                    strobe_nxt  = 1'b1;
                    tx_data_nxt = rd_data;
                    rd_addr_nxt = rd_addr + 1'b1;
                    state_nxt   = ST_BYTE_WAIT;
                end
            end
            ST_BYTE_WAIT: begin
                // rd_addr wraps to zero only after index DEPTH-1 was sent
                state_nxt = (rd_addr == '0) ? ST_DONE : ST_SEND;
            end
            ST_DONE: begin
                rd_addr_nxt = '0;
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            tip_q               <= 1'b0;
            hold_cnt            <= '0;
            wr_addr             <= '0;
            rd_addr             <= '0;
            prefetched          <= 1'b0;
            bus.new_tx_data     <= 1'b0;
            bus.tx_data         <= '0;
            capture_in_progress <= 1'b0;
            busy                <= 1'b0;
            record_done         <= 1'b0;
        end else begin
            state               <= state_nxt;
            tip_q               <= transmit_in_progress;
            hold_cnt            <= hold_cnt_nxt;
            wr_addr             <= wr_addr_nxt;
            rd_addr             <= rd_addr_nxt;
            // RAM data is valid from the second cycle spent in SEND
            prefetched          <= (state == ST_SEND) && (state_nxt == ST_SEND);
            bus.new_tx_data     <= strobe_nxt;
            bus.tx_data         <= tx_data_nxt;
            capture_in_progress <= (state_nxt == ST_HOLDOFF) || (state_nxt == ST_CAPTURE);
            busy                <= (state_nxt != ST_IDLE);
            record_done         <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_image_receive_fsm.sv
// Scoreboard bench for image_receive_fsm (DEPTH=8, HOLDOFF=4). Stimulus pushes
// the expected UART byte stream into a queue; a negedge monitor pops and
// compares on every new_tx_data strobe and checks the handshake rules.
module tb_image_receive_fsm;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned HOLDOFF = 4;
    localparam logic [7:0]  HDR     = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    logic tip;
    logic cap;
    logic busy_o;
    logic rec_done;

    image_receive_fsm_if bus ();

    int         total       = 0;
    int         bad         = 0;
    int         strobe_cnt  = 0;
    int         done_cnt    = 0;
    int         exp_done    = 0;
    int         uart_cnt    = 0;
    logic       force_busy  = 1'b0;
    logic       hold_chk_en = 1'b0;
    logic [7:0] exp_q[$];

    image_receive_fsm #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .transmit_in_progress (tip),
        .bus                  (bus),
        .capture_in_progress  (cap),
        .busy                 (busy_o),
        .record_done          (rec_done)
    );

    always #5 clk = ~clk;

    // UART model: busy from the cycle after a strobe, for 10 cycles
    always @(posedge clk) begin
        if (bus.new_tx_data) uart_cnt <= 10;
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end
    assign bus.tx_busy = (uart_cnt != 0) || force_busy;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic       prev_strobe = 1'b0;
        logic       done_last   = 1'b0;
        logic [7:0] last_tx     = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.new_tx_data) begin
                strobe_cnt++;
                check("strobe_while_busy", int'(bus.tx_busy), 0);
                check("strobe_back_to_back", int'(prev_strobe), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %02h with empty queue", bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", int'(bus.tx_data), int'(e));
                end
            end else if (hold_chk_en) begin
                check("tx_data_hold", int'(bus.tx_data), int'(last_tx));
            end
            if (rec_done) begin
                done_cnt++;
                check("busy_during_done", int'(busy_o), 1);
            end
            if (done_last) check("busy_after_done", int'(busy_o), 0);
            prev_strobe = bus.new_tx_data;
            done_last   = rec_done;
            last_tx     = bus.tx_data;
        end
    end

    // Arm a capture: tip 1->0, then 0xFF samples through the blanked cycles.
    // The first real sample lands on the first cycle after HOLDOFF blanked cycles.
    task automatic capture(input logic [7:0] base, input bit toggle);
        @(negedge clk);
        tip = 1'b1;
        bus.adc_valid = 1'b0;
        repeat (2) @(negedge clk);
        tip = 1'b0;
        bus.adc_valid = 1'b1;
        bus.adc_data  = 8'hFF;
        for (int i = 0; i < int'(HOLDOFF); i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("cap_in_holdoff", int'(cap), 1);
                check("busy_in_holdoff", int'(busy_o), 1);
            end
        end
        exp_q.push_back(HDR);
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            bus.adc_valid = 1'b1;
            bus.adc_data  = base + 8'(i);
            exp_q.push_back(base + 8'(i));
            if (toggle) begin
                @(negedge clk);
                bus.adc_valid = 1'b0;
                bus.adc_data  = 8'hEE;
            end
        end
        @(negedge clk);
        bus.adc_valid = 1'b0;
        bus.adc_data  = 8'h00;
    endtask

    task automatic wait_done();
        exp_done++;
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt >= exp_done) break;
            @(negedge clk);
        end
        check("record_done_count", done_cnt, exp_done);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_strobes(input int target);
        for (int k = 0; k < 3000; k++) begin
            if (strobe_cnt >= target) break;
            @(negedge clk);
        end
        check("strobes_reached", int'(strobe_cnt >= target), 1);
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        tip = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_data", int'(bus.tx_data), 0);
        check("rst_new_tx_data", int'(bus.new_tx_data), 0);
        check("rst_cap", int'(cap), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_record_done", int'(rec_done), 0);
        rst = 1'b0;
        hold_chk_en = 1'b1;

        // Continuous samples
        capture(8'h10, 1'b0);
        wait_done();

        // adc_valid toggling
        capture(8'h80, 1'b1);
        wait_done();

        // tx_busy forced high for 50 cycles around SEND entry
        s0 = strobe_cnt;
        capture(8'h30, 1'b0);
        wait_strobes(s0 + 1);
        force_busy = 1'b1;
        s0 = strobe_cnt;
        repeat (50) @(negedge clk);
        check("no_strobe_forced_busy", strobe_cnt, s0);
        force_busy = 1'b0;
        wait_done();

        // Reset in the middle of sending, then a clean restart
        s0 = strobe_cnt;
        capture(8'h40, 1'b0);
        wait_strobes(s0 + 3);
        hold_chk_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx_data", int'(bus.tx_data), 0);
        check("midrst_new_tx_data", int'(bus.new_tx_data), 0);
        check("midrst_cap", int'(cap), 0);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_record_done", int'(rec_done), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        hold_chk_en = 1'b1;
        capture(8'h50, 1'b0);
        wait_done();

        // Second falling edge during SEND is ignored
        s0 = strobe_cnt;
        capture(8'h60, 1'b0);
        wait_strobes(s0 + 3);
        tip = 1'b1;
        repeat (2) @(negedge clk);
        tip = 1'b0;
        repeat (2) @(negedge clk);
        check("ignored_arm_cap", int'(cap), 0);
        wait_done();
        capture(8'h70, 1'b0);
        wait_done();

        check("final_done_count", done_cnt, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
